// File: rtl/z8420_pkg.sv
// Shared constants, FSM encoding and the mode-3 match function for the Z8420 PIO port controller.
package z8420_pkg;

    localparam logic [1:0] MODE_OUT   = 2'b00;
    localparam logic [1:0] MODE_IN    = 2'b01;
    localparam logic [1:0] MODE_BIDIR = 2'b10;
    localparam logic [1:0] MODE_BIT   = 2'b11;

    localparam logic [3:0] CW_MODE = 4'hF;
    localparam logic [3:0] CW_IC   = 4'h7;
    localparam logic [3:0] CW_IE   = 4'h3;

    typedef enum logic [1:0] {
        S_CMD,
        S_IOSEL,
        S_MASK
    } state_t;

    // Bit-control match: only unmasked input bits take part; with none active the
    // condition is false for both AND and OR, so an all-masked port never fires.
    function automatic logic bit_match(input logic [7:0] s,
                                       input logic [7:0] mask,
                                       input logic [7:0] iosel,
                                       input logic       high,
                                       input logic       and_fn);
        logic [7:0] active;
        logic [7:0] hit;
        active = ~mask & iosel;
        hit    = high ? s : ~s;
        if (and_fn)
            return (active != 8'h00) && ((active & ~hit) == 8'h00);
        else
            return |(active & hit);
    endfunction

endpackage

// File: rtl/pio_sync.sv
// Multi-stage flop synchroniser for asynchronous port pins and the handshake strobe.
module pio_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] pipe;

    // NOTE: non-blocking assignment so every stage shifts from the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst)
            pipe <= '0;
        else
            pipe <= {pipe[STAGES-2:0], d};
    end

    assign q = pipe[STAGES-1];

endmodule

// File: rtl/pio_port_ctrl.sv
// Z8420 PIO per-port control-word decoder and interrupt-condition generator feeding
// the port's daisy-chain stage (INTI request pulse, INTEN level, vector byte).
module pio_port_ctrl
    import z8420_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CTRL_WR,
    input  logic [7:0] DI,
    input  logic [7:0] PIN,
    input  logic       STB_n,
    output logic [1:0] MODE,
    output logic [7:0] IOSEL,
    output logic [7:0] VECTOR,
    output logic       INTEN,
    output logic       INTI
);

    state_t     state_q, state_d;
    logic [1:0] mode_q;
    logic [7:0] iosel_q, mask_q, vector_q;
    logic       inten_q, and_q, high_q;
    logic       match, match_q, inti_q;
    logic [7:0] s_pin;
    logic       s_stb;
    logic       in_mask;

    logic ld_vector, ld_mode, ld_ic, ld_ie, ld_iosel, ld_mask;

    pio_sync #(.WIDTH(8), .STAGES(SYNC_STAGES)) u_sync_pin (
        .clk (CLK),
        .rst (RESET),
        .d   (PIN),
        .q   (s_pin)
    );

    pio_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_stb (
        .clk (CLK),
        .rst (RESET),
        .d   (STB_n),
        .q   (s_stb)
    );

    always_ff @(posedge CLK) begin
        if (RESET)
            state_q <= S_CMD;
        else
            state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        ld_vector = 1'b0;
        ld_mode   = 1'b0;
        ld_ic     = 1'b0;
        ld_ie     = 1'b0;
        ld_iosel  = 1'b0;
        ld_mask   = 1'b0;
        if (CTRL_WR) begin
            case (state_q)
                S_IOSEL: begin
                    ld_iosel = 1'b1;
                    state_d  = S_CMD;
                end
                S_MASK: begin
                    ld_mask = 1'b1;
                    state_d = S_CMD;
                end
                default: begin
                    state_d = S_CMD;
                    if (!DI[0]) begin
                        ld_vector = 1'b1;
                    end else if (DI[3:0] == CW_MODE) begin
                        ld_mode = 1'b1;
                        if (DI[7:6] == MODE_BIT) state_d = S_IOSEL;
                    end else if (DI[3:0] == CW_IC) begin
                        ld_ic = 1'b1;
                        if (DI[4]) state_d = S_MASK;
                    end else if (DI[3:0] == CW_IE) begin
                        ld_ie = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            mode_q   <= MODE_IN;
            iosel_q  <= 8'hFF;
            mask_q   <= 8'hFF;
            vector_q <= 8'h00;
            inten_q  <= 1'b0;
            and_q    <= 1'b0;
            high_q   <= 1'b0;
        end else begin
            if (ld_vector) vector_q <= DI;
            if (ld_mode)   mode_q   <= DI[7:6];
            if (ld_iosel)  iosel_q  <= DI;
            if (ld_mask)   mask_q   <= DI;
            if (ld_ic) begin
                inten_q <= DI[7];
                and_q   <= DI[6];
                high_q  <= DI[5];
            end
            if (ld_ie)     inten_q  <= DI[7];
        end
    end

    always_comb begin
        match = 1'b0;
        case (mode_q)
            MODE_OUT, MODE_IN, MODE_BIDIR: match = s_stb;
            MODE_BIT: match = bit_match(s_pin, mask_q, iosel_q, high_q, and_q);
            default:  match = 1'b0;
        endcase
    end

    assign in_mask = (state_q == S_MASK);

    // match_q is held low while awaiting the mask so a condition already true on
    // exit from S_MASK is seen as a fresh rising edge.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            match_q <= 1'b0;
            inti_q  <= 1'b0;
        end else begin
            match_q <= match & ~in_mask;
            inti_q  <= match & ~match_q & ~in_mask;
        end
    end

    assign MODE   = mode_q;
    assign IOSEL  = iosel_q;
    assign VECTOR = {vector_q[7:1], 1'b0};
    assign INTEN  = inten_q & ~in_mask;
    assign INTI   = inti_q;

endmodule
